// File: rtl/vis_frame_packer_pkg.sv
// Shared definitions for the visibility frame packer.
//   vis_state_e  : packer FSM states
//   VIS_*        : default width, pairs per frame and header sync pattern
//   vis_hdr0()   : builds header word 0 as {magic, pair count}
package vis_frame_packer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      RE,
      IM,
      WAIT,
      DROP
   } vis_state_e;

   localparam int unsigned VIS_WIDTH  = 32;
   localparam int unsigned VIS_NPAIRS = 10;
   localparam logic [15:0] VIS_MAGIC  = 16'hA5C3;

   // Header word 0 layout: magic in [31:16], advertised pair count in [15:0].
   localparam int unsigned HDR_MAGIC_LSB = 16;
   localparam int unsigned HDR_COUNT_W   = 16;

   function automatic logic [31:0] vis_hdr0(input logic [15:0] magic,
                                            input logic [HDR_COUNT_W-1:0] npairs);
      return {magic, npairs};
   endfunction

endpackage

// File: rtl/vis_frame_packer_if.sv
// Stream bundle around the packer.
//   s_* : visibility pair input (valid/ready/last, real and imag components)
//   m_* : packed word output (valid/ready/last, data)
// modport master : the packer itself (consumes s_*, produces m_*)
// modport slave  : the surrounding environment (produces s_*, consumes m_*)
interface vis_frame_packer_if
   import vis_frame_packer_pkg::*;
#(
   parameter int unsigned WIDTH = VIS_WIDTH
);
   logic             s_valid_i;
   logic             s_ready_o;
   logic             s_last_i;
   logic [WIDTH-1:0] s_revis_i;
   logic [WIDTH-1:0] s_imvis_i;
   logic             m_valid_o;
   logic             m_ready_i;
   logic             m_last_o;
   logic [WIDTH-1:0] m_data_o;

   modport master (
      input  s_valid_i, s_last_i, s_revis_i, s_imvis_i, m_ready_i,
      output s_ready_o, m_valid_o, m_last_o, m_data_o
   );

   modport slave (
      output s_valid_i, s_last_i, s_revis_i, s_imvis_i, m_ready_i,
      input  s_ready_o, m_valid_o, m_last_o, m_data_o
   );
endinterface

// File: rtl/vis_frame_packer.sv
// Packs a visibility pair stream into a word stream for readout:
// two header words ({MAGIC,NPAIRS}, frame index) then RE/IM per pair.
// Short frames end early, long frames are truncated at NPAIRS with the
// excess discarded; both raise a one-cycle len_err_o pulse.
// Ports:
//   bus_clock  : sole clock
//   bus_reset  : synchronous, active-high reset
//   bus        : stream bundle (master modport), see vis_frame_packer_if
//   frames_o   : count of completed output frames (wraps)
//   len_err_o  : one-cycle pulse when a frame length differs from NPAIRS
module vis_frame_packer
   import vis_frame_packer_pkg::*;
#(
   parameter int unsigned WIDTH  = VIS_WIDTH,
   parameter int unsigned NPAIRS = VIS_NPAIRS,
   parameter logic [15:0] MAGIC  = VIS_MAGIC
) (
   input  logic                bus_clock,
   input  logic                bus_reset,
   vis_frame_packer_if.master  bus,
   output logic [31:0]         frames_o,
   output logic                len_err_o
);

   localparam int unsigned     PW        = $clog2(NPAIRS + 1);
   localparam logic [PW-1:0]   NP        = PW'(NPAIRS);
   localparam logic [WIDTH-1:0] HDR0_WORD = WIDTH'(vis_hdr0(MAGIC, HDR_COUNT_W'(NPAIRS)));

   vis_state_e       state;
   logic [PW-1:0]    pcnt;
   logic [WIDTH-1:0] hold_re;
   logic [WIDTH-1:0] hold_im;
   logic             hold_last;
   logic             m_valid_r;
   logic             m_last_r;
   logic [WIDTH-1:0] m_data_r;
   logic [31:0]      frames_r;
   logic             len_err_r;

   logic             fin;
   logic             s_ready;
   logic             s_xfer;
   logic             m_xfer;

   // The pair in the hold regs closes the frame: marked last, or length cap hit.
   assign fin = hold_last || (pcnt == NP);

   // Input is refused while in reset; in IM it follows downstream ready so the
   // next pair can be captured on the same edge the IM word leaves.
   always_comb begin
      s_ready = 1'b0;
      if (!bus_reset) begin
         unique case (state)
            IDLE, WAIT, DROP: s_ready = 1'b1;
            IM:               s_ready = bus.m_ready_i && !fin;
            default:          s_ready = 1'b0;
         endcase
      end
   end

   assign s_xfer = bus.s_valid_i && s_ready;
   assign m_xfer = m_valid_r && bus.m_ready_i;

   always_ff @(posedge bus_clock) begin
      if (bus_reset) begin
         state     <= IDLE;
         pcnt      <= '0;
         hold_re   <= '0;
         hold_im   <= '0;
         hold_last <= 1'b0;
         m_valid_r <= 1'b0;
         m_last_r  <= 1'b0;
         m_data_r  <= '0;
         frames_r  <= '0;
         len_err_r <= 1'b0;
      end else begin
         len_err_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (s_xfer) begin
                  hold_re   <= bus.s_revis_i;
                  hold_im   <= bus.s_imvis_i;
                  hold_last <= bus.s_last_i;
                  pcnt      <= PW'(1);
                  m_valid_r <= 1'b1;
                  m_last_r  <= 1'b0;
                  m_data_r  <= HDR0_WORD;
                  state     <= HDR0;
               end
            end
            HDR0: begin
               if (m_xfer) begin
                  m_data_r <= WIDTH'(frames_r);
                  state    <= HDR1;
               end
            end
            HDR1: begin
               if (m_xfer) begin
                  m_data_r <= hold_re;
                  state    <= RE;
               end
            end
            RE: begin
               if (m_xfer) begin
                  m_data_r <= hold_im;
                  m_last_r <= fin;
                  state    <= IM;
               end
            end
            IM: begin
               if (m_xfer) begin
                  m_last_r <= 1'b0;
                  if (fin) begin
                     frames_r  <= frames_r + 32'd1;
                     // Only a last-flagged pair landing exactly on NPAIRS is a good frame;
                     // fin without last means the cap was hit and the frame is too long.
                     len_err_r <= !(hold_last && (pcnt == NP));
                     m_valid_r <= 1'b0;
                     state     <= hold_last ? IDLE : DROP;
                  end else if (s_xfer) begin
                     hold_re   <= bus.s_revis_i;
                     hold_im   <= bus.s_imvis_i;
                     hold_last <= bus.s_last_i;
                     pcnt      <= pcnt + PW'(1);
                     m_data_r  <= bus.s_revis_i;
                     state     <= RE;
                  end else begin
                     m_valid_r <= 1'b0;
                     state     <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (s_xfer) begin
                  hold_re   <= bus.s_revis_i;
                  hold_im   <= bus.s_imvis_i;
                  hold_last <= bus.s_last_i;
                  pcnt      <= pcnt + PW'(1);
                  m_valid_r <= 1'b1;
                  m_data_r  <= bus.s_revis_i;
                  state     <= RE;
               end
            end
            DROP: begin
               if (s_xfer && bus.s_last_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.s_ready_o = s_ready;
   assign bus.m_valid_o = m_valid_r;
   assign bus.m_last_o  = m_last_r;
   assign bus.m_data_o  = m_data_r;
   assign frames_o      = frames_r;
   assign len_err_o     = len_err_r;

endmodule
